// File: rtl/utm_step_controller_pkg.sv
// Shared types and constants for the Turing-machine step controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package utm_step_controller_pkg;

    // Controller FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_HALT  = 3'd3,
        ST_FAULT = 3'd4
    } fsm_e;

    localparam int SYM_W_DEF      = 3;
    localparam int STATE_W_DEF    = 3;
    localparam int HALT_STATE_DEF = 7;
    localparam int BLANK_SYM      = 0;

endpackage

// File: rtl/utm_step_controller_tape_regfile.sv
// Tape storage: TAPE_LEN x SYM_W flops, one sync write port, two async read ports.
// Latency: write visible on reads the cycle after the write edge; reads are combinational.
// Backpressure: none, the write port is always accepted.
// Ports: clk/rst_n (async clear to BLANK_SYM), wr_en/wr_addr/wr_sym write port,
//        hd_addr/hd_sym head read port, rd_addr/rd_sym readback port.
module utm_tape_regfile
    import utm_step_controller_pkg::*;
#(
    parameter int TAPE_LEN = 16,
    parameter int SYM_W    = SYM_W_DEF,
    parameter int AW       = $clog2(TAPE_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [SYM_W-1:0] wr_sym,
    input  logic [AW-1:0]    hd_addr,
    output logic [SYM_W-1:0] hd_sym,
    input  logic [AW-1:0]    rd_addr,
    output logic [SYM_W-1:0] rd_sym
);

    logic [SYM_W-1:0] tape_q [TAPE_LEN];
    logic [SYM_W-1:0] tape_d [TAPE_LEN];

    always_comb begin
        tape_d = tape_q;
        if (wr_en) begin
            tape_d[wr_addr] = wr_sym;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPE_LEN; i++) begin
                tape_q[i] <= SYM_W'(BLANK_SYM);
            end
        end else begin
            tape_q <= tape_d;
        end
    end

    assign hd_sym = tape_q[hd_addr];
    assign rd_sym = tape_q[rd_addr];

endmodule

// File: rtl/utm_step_controller.sv
// Runs an external combinational TM transition block: load tape, fetch/execute steps, readback.
// Latency: 2 cycles per step (FETCH then EXEC); readback is combinational.
// Backpressure: load_ready is high only in IDLE; start is ignored unless IDLE; abort always wins.
// Ports: load_valid/load_sym/load_ready tape load; start/head_init/abort run control;
//        tm_* interface to the transition block; rd_addr/rd_sym readback;
//        busy/halted/fault/head_pos/step_count status.
// Optional: define UTM_STEP_LIMIT_EN to add the MAX_STEPS budget and the timeout output.
module utm_step_controller
    import utm_step_controller_pkg::*;
#(
    parameter int TAPE_LEN   = 16,
    parameter int SYM_W      = SYM_W_DEF,
    parameter int STATE_W    = STATE_W_DEF,
    parameter int HALT_STATE = HALT_STATE_DEF,
    parameter int MAX_STEPS  = 1000,
    parameter int AW         = $clog2(TAPE_LEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_valid,
    input  logic [SYM_W-1:0]   load_sym,
    output logic               load_ready,
    input  logic               start,
    input  logic [AW-1:0]      head_init,
    input  logic               abort,
    output logic [STATE_W-1:0] tm_state,
    output logic [SYM_W-1:0]   tm_sym,
    input  logic [STATE_W-1:0] tm_next_state,
    input  logic [SYM_W-1:0]   tm_new_sym,
    input  logic               tm_move_right,
    input  logic [AW-1:0]      rd_addr,
    output logic [SYM_W-1:0]   rd_sym,
    output logic               busy,
    output logic               halted,
    output logic               fault,
`ifdef UTM_STEP_LIMIT_EN
    output logic               timeout,
`endif
    output logic [AW-1:0]      head_pos,
    output logic [15:0]        step_count
);

    fsm_e               fsm_q, fsm_d;
    logic [AW-1:0]      load_ptr_q, load_ptr_d;
    logic [AW-1:0]      head_pos_q, head_pos_d;
    logic [STATE_W-1:0] tm_state_q, tm_state_d;
    logic [SYM_W-1:0]   tm_sym_q, tm_sym_d;
    logic [15:0]        step_count_q, step_count_d;

    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [SYM_W-1:0]   wr_sym;
    logic [SYM_W-1:0]   hd_sym;

    logic               halting;
    logic               at_edge;
    logic               limit_hit;
    logic [15:0]        step_inc;

    assign halting  = (tm_next_state == STATE_W'(HALT_STATE));
    // Moving off either end of the tape is a fault, not a wrap.
    assign at_edge  = tm_move_right ? (head_pos_q == AW'(TAPE_LEN - 1))
                                    : (head_pos_q == '0);
    assign step_inc = (step_count_q == 16'hFFFF) ? 16'hFFFF : step_count_q + 16'd1;

`ifdef UTM_STEP_LIMIT_EN
    logic timeout_q, timeout_d;
    assign limit_hit = ({1'b0, step_count_q} + 17'd1) == 17'(MAX_STEPS);
    assign timeout   = timeout_q;
`else
    assign limit_hit = 1'b0;
`endif

    utm_tape_regfile #(
        .TAPE_LEN (TAPE_LEN),
        .SYM_W    (SYM_W)
    ) u_tape (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_sym  (wr_sym),
        .hd_addr (head_pos_q),
        .hd_sym  (hd_sym),
        .rd_addr (rd_addr),
        .rd_sym  (rd_sym)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q        <= ST_IDLE;
            load_ptr_q   <= '0;
            head_pos_q   <= '0;
            tm_state_q   <= '0;
            tm_sym_q     <= '0;
            step_count_q <= '0;
`ifdef UTM_STEP_LIMIT_EN
            timeout_q    <= 1'b0;
`endif
        end else begin
            fsm_q        <= fsm_d;
            load_ptr_q   <= load_ptr_d;
            head_pos_q   <= head_pos_d;
            tm_state_q   <= tm_state_d;
            tm_sym_q     <= tm_sym_d;
            step_count_q <= step_count_d;
`ifdef UTM_STEP_LIMIT_EN
            timeout_q    <= timeout_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        fsm_d = fsm_q;
        if (abort) begin
            fsm_d = ST_IDLE;
        end else begin
            case (fsm_q)
                ST_IDLE:  if (start) fsm_d = ST_FETCH;
                ST_FETCH: fsm_d = ST_EXEC;
                ST_EXEC: begin
                    if (halting)                  fsm_d = ST_HALT;
                    else if (limit_hit || at_edge) fsm_d = ST_FAULT;
                    else                          fsm_d = ST_FETCH;
                end
                ST_HALT:  fsm_d = ST_HALT;
                ST_FAULT: fsm_d = ST_FAULT;
                default:  fsm_d = ST_IDLE;
            endcase
        end
    end

    // Datapath updates; abort suppresses every commit, including a same-cycle load.
    always_comb begin
        load_ptr_d   = load_ptr_q;
        head_pos_d   = head_pos_q;
        tm_state_d   = tm_state_q;
        tm_sym_d     = tm_sym_q;
        step_count_d = step_count_q;
        wr_en        = 1'b0;
        wr_addr      = head_pos_q;
        wr_sym       = tm_new_sym;
`ifdef UTM_STEP_LIMIT_EN
        timeout_d    = timeout_q;
        if (abort) begin
            timeout_d = 1'b0;
        end else if (fsm_q == ST_IDLE && start) begin
            timeout_d = 1'b0;
        end else if (fsm_q == ST_EXEC && !halting && limit_hit) begin
            timeout_d = 1'b1;
        end
`endif
        if (!abort) begin
            case (fsm_q)
                ST_IDLE: begin
                    if (load_valid) begin
                        wr_en      = 1'b1;
                        wr_addr    = load_ptr_q;
                        wr_sym     = load_sym;
                        load_ptr_d = load_ptr_q + AW'(1);
                    end
                    // start overrides the pointer increment; the load itself still lands.
                    if (start) begin
                        head_pos_d   = head_init;
                        tm_state_d   = '0;
                        step_count_d = '0;
                        load_ptr_d   = '0;
                    end
                end
                ST_FETCH: tm_sym_d = hd_sym;
                ST_EXEC: begin
                    wr_en        = 1'b1;
                    tm_state_d   = tm_next_state;
                    step_count_d = step_inc;
                    if (fsm_d == ST_FETCH) begin
                        head_pos_d = tm_move_right ? head_pos_q + AW'(1) : head_pos_q - AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        load_ready = (fsm_q == ST_IDLE);
        busy       = (fsm_q == ST_FETCH) || (fsm_q == ST_EXEC);
        halted     = (fsm_q == ST_HALT);
        fault      = (fsm_q == ST_FAULT);
    end

    assign tm_state   = tm_state_q;
    assign tm_sym     = tm_sym_q;
    assign head_pos   = head_pos_q;
    assign step_count = step_count_q;

endmodule
